// File: rtl/pfu_fetch_pkg.sv
// Shared definitions for the prefetch unit: widths, RISC-V major opcodes,
// the buffered fetch entry layout and the jump/branch pre-decode helper.
package pfu_fetch_pkg;

  localparam int INST_WIDTH   = 32;
  localparam int PFU_PC_WIDTH = 32;
  localparam int STC_PC_WIDTH = PFU_PC_WIDTH;
  localparam int GHSR_WIDTH   = 8;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OP_OP     = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;

  typedef struct packed {
    logic [INST_WIDTH-1:0]   inst;
    logic [PFU_PC_WIDTH-1:0] pc;
    logic [GHSR_WIDTH-1:0]   ghsr;
    logic                    jb;
  } fetch_entry_t;

  function automatic logic is_jb(input logic [INST_WIDTH-1:0] inst);
    logic jb_s;
    case (inst[6:0])
      OP_JAL, OP_JALR, OP_BRANCH: jb_s = 1'b1;
      default:                    jb_s = 1'b0;
    endcase
    return jb_s;
  endfunction

endpackage

// File: rtl/pfu_fetch_if.sv
// Instruction-memory, decode and stage-control signals of the prefetch unit.
// master = prefetch unit, slave = its environment.
interface pfu_fetch_if;
  import pfu_fetch_pkg::*;

  logic                    imem_req_o;
  logic [PFU_PC_WIDTH-1:0] imem_addr_o;
  logic                    imem_gnt_i;
  logic                    imem_rvld_i;
  logic [INST_WIDTH-1:0]   imem_rdata_i;
  logic                    pfu_vld_o;
  logic                    dcu_rdy_i;
  logic [INST_WIDTH-1:0]   pfu_inst_o;
  logic [PFU_PC_WIDTH-1:0] pfu_pc_o;
  logic [GHSR_WIDTH-1:0]   pfu_ghsr_o;
  logic                    pfu_j_b_en_o;
  logic                    stc_stall_i;
  logic                    stc_redirect_i;
  logic [STC_PC_WIDTH-1:0] stc_pc_i;
  logic [GHSR_WIDTH-1:0]   stc_ghsr_i;

  modport master (
    output imem_req_o, imem_addr_o, pfu_vld_o, pfu_inst_o, pfu_pc_o, pfu_ghsr_o, pfu_j_b_en_o,
    input  imem_gnt_i, imem_rvld_i, imem_rdata_i, dcu_rdy_i,
           stc_stall_i, stc_redirect_i, stc_pc_i, stc_ghsr_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, pfu_vld_o, pfu_inst_o, pfu_pc_o, pfu_ghsr_o, pfu_j_b_en_o,
    output imem_gnt_i, imem_rvld_i, imem_rdata_i, dcu_rdy_i,
           stc_stall_i, stc_redirect_i, stc_pc_i, stc_ghsr_i
  );

endinterface

// File: rtl/pfu_fifo.sv
// Synchronous FIFO with flush and occupancy count; storage clears on reset so
// the head reads as zero until the first push.
module pfu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             push_s;
  logic             pop_s;

  assign empty  = (cnt_r == {CW{1'b0}});
  assign full   = (cnt_r == CW'(DEPTH));
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_r[rd_ptr_r];
  assign count  = cnt_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1'b1);
        2'b01:   cnt_r <= cnt_r - CW'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/pfu_fetch.sv
// Instruction prefetch unit: credit-limited in-order fetch, pre-decode with
// GHSR tagging, buffered hand-off to decode, stall and redirect handling.
module pfu_fetch
  import pfu_fetch_pkg::*;
#(
  parameter int                      FIFO_DEPTH = 2,
  parameter logic [PFU_PC_WIDTH-1:0] RESET_PC   = {PFU_PC_WIDTH{1'b0}}
) (
  input  logic        fclk_i,
  input  logic        rst_i,
  pfu_fetch_if.master bus
);

  localparam int                      CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]           CNT_ZERO = {CW{1'b0}};
  localparam logic [PFU_PC_WIDTH-1:0] PC_STEP  = PFU_PC_WIDTH'(32'd4);

  logic [PFU_PC_WIDTH-1:0] fetch_pc_r;
  logic [PFU_PC_WIDTH-1:0] rsp_pc_r;
  logic [PFU_PC_WIDTH-1:0] redir_pc_s;
  logic [GHSR_WIDTH-1:0]   ghsr_r;
  logic [CW-1:0]           outstanding_r;
  logic [CW-1:0]           discard_r;
  logic [CW-1:0]           out_nxt_s;
  logic [CW-1:0]           discard_nxt_s;
  logic [CW-1:0]           fifo_cnt_s;
  logic [CW:0]             credit_sum_s;
  logic                    fifo_empty_s;
  logic                    fifo_full_s;
  logic                    req_s;
  logic                    grant_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    vld_s;
  fetch_entry_t            entry_in_s;
  fetch_entry_t            head_s;

  assign redir_pc_s   = bus.stc_pc_i & ~(STC_PC_WIDTH'(32'd3));
  assign credit_sum_s = {1'b0, fifo_cnt_s} + {1'b0, outstanding_r};

  // Outstanding requests are counted against buffer space so a response always has a slot.
  assign req_s   = rst_i && !bus.stc_stall_i && !bus.stc_redirect_i
                 && (credit_sum_s < (CW + 1)'(FIFO_DEPTH)) && (discard_r == CNT_ZERO);
  assign grant_s = req_s && bus.imem_gnt_i;
  assign push_s  = bus.imem_rvld_i && !bus.stc_redirect_i && (discard_r == CNT_ZERO) && !fifo_full_s;
  assign vld_s   = !fifo_empty_s && !bus.stc_stall_i && !bus.stc_redirect_i;
  assign pop_s   = vld_s && bus.dcu_rdy_i;

  assign entry_in_s.inst = bus.imem_rdata_i;
  assign entry_in_s.pc   = rsp_pc_r;
  assign entry_in_s.ghsr = ghsr_r;
  assign entry_in_s.jb   = is_jb(bus.imem_rdata_i);

  pfu_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (fclk_i),
    .rst_n (rst_i),
    .flush (bus.stc_redirect_i),
    .push  (push_s),
    .wdata (entry_in_s),
    .pop   (pop_s),
    .rdata (head_s),
    .count (fifo_cnt_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Next outstanding and discard counts; a redirect discards whatever is still in flight.
  always_comb begin
    out_nxt_s     = outstanding_r;
    discard_nxt_s = discard_r;
    case ({grant_s, bus.imem_rvld_i})
      2'b10:   out_nxt_s = outstanding_r + CW'(1'b1);
      2'b01:   out_nxt_s = outstanding_r - CW'(1'b1);
      default: out_nxt_s = outstanding_r;
    endcase
    if (bus.stc_redirect_i) begin
      discard_nxt_s = out_nxt_s;
    end else if (bus.imem_rvld_i && (discard_r != CNT_ZERO)) begin
      discard_nxt_s = discard_r - CW'(1'b1);
    end else begin
      discard_nxt_s = discard_r;
    end
  end

  // Request bookkeeping registers.
  always_ff @(posedge fclk_i or negedge rst_i) begin
    if (!rst_i) begin
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
    end else begin
      outstanding_r <= out_nxt_s;
      discard_r     <= discard_nxt_s;
    end
  end

  // Fetch PC, response PC and global history.
  always_ff @(posedge fclk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      ghsr_r     <= {GHSR_WIDTH{1'b0}};
    end else if (bus.stc_redirect_i) begin
      fetch_pc_r <= redir_pc_s;
      rsp_pc_r   <= redir_pc_s;
      ghsr_r     <= bus.stc_ghsr_i;
    end else begin
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + PC_STEP;
        // Static not-taken prediction shifts a zero in; the entry keeps the pre-shift history.
        if (entry_in_s.jb) begin
          ghsr_r <= {ghsr_r[GHSR_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.imem_req_o   = req_s;
  assign bus.imem_addr_o  = fetch_pc_r;
  assign bus.pfu_vld_o    = vld_s;
  assign bus.pfu_inst_o   = head_s.inst;
  assign bus.pfu_pc_o     = head_s.pc;
  assign bus.pfu_ghsr_o   = head_s.ghsr;
  assign bus.pfu_j_b_en_o = head_s.jb;

endmodule

// File: doc/pfu_fetch.md
Name: pfu_fetch

Overview:
Instruction prefetch unit that produces the fetch stream consumed by the decode unit.
- Issues in-order word fetches to instruction memory and buffers the returned instructions in a small FIFO.
- Pre-decodes each instruction for jump/branch and tags it with PC and a GHSR snapshot.
- Presents instructions to decode over the pfu_vld/dcu_rdy handshake.
- Obeys stage-control stall and redirect.

Parameters:
- INST_WIDTH, 32, instruction width.
- PFU_PC_WIDTH, 32, PC and fetch address width.
- STC_PC_WIDTH, 32, redirect PC width; must equal PFU_PC_WIDTH.
- GHSR_WIDTH, 8, global history shift register width.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- RESET_PC, 0, PC fetched first after reset.

Ports:
- fclk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PFU_PC_WIDTH  fetch address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvld_i  in  1  read data valid; responses return in order.
- imem_rdata_i  in  INST_WIDTH  read data.
- pfu_vld_o  out  1  instruction valid to decode.
- dcu_rdy_i  in  1  decode ready.
- pfu_inst_o  out  INST_WIDTH  instruction.
- pfu_pc_o  out  PFU_PC_WIDTH  instruction PC.
- pfu_ghsr_o  out  GHSR_WIDTH  GHSR snapshot taken at enqueue.
- pfu_j_b_en_o  out  1  instruction is JAL, JALR or BRANCH.
- stc_stall_i  in  1  stall.
- stc_redirect_i  in  1  flush and redirect.
- stc_pc_i  in  STC_PC_WIDTH  redirect target.
- stc_ghsr_i  in  GHSR_WIDTH  GHSR restore value on redirect.

Behaviour:
- Reset, while rst_i=0:
  - fetch_pc=RESET_PC, ghsr=0, FIFO empty, outstanding=0, discard=0.
  - All outputs 0, except imem_addr_o=RESET_PC.
- Credit: imem_req_o = !stc_stall_i && !stc_redirect_i && (fifo_cnt + outstanding < FIFO_DEPTH) && (discard==0).
  - Combinational; imem_addr_o = fetch_pc.
- Grant, imem_req_o && imem_gnt_i: fetch_pc += 4, wrapping modulo 2^PFU_PC_WIDTH; outstanding += 1.
- Response, imem_rvld_i:
  - outstanding -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise push {rdata, pc, ghsr, jb} into the FIFO. pc comes from a response-PC counter that advances by 4 per accepted response.
  - Grant and response in the same cycle leave outstanding unchanged.
- Pre-decode: jb=1 when opcode[6:0] is 110_1111, 110_0111 or 110_0011.
  - For a pushed jb instruction, ghsr <= {ghsr[GHSR_WIDTH-2:0],1'b0} (static not-taken).
  - The snapshot stored with the instruction is the pre-shift value.
- Output: pfu_vld_o and pfu_*_o reflect the FIFO head. pfu_vld_o = !empty && !stc_stall_i && !stc_redirect_i.
  - Pop when pfu_vld_o && dcu_rdy_i.
  - A push into an empty FIFO is visible one cycle later.
  - A simultaneous push and pop when full is not possible, because credit prevents overflow.
- Stall: no request, no pop; FIFO contents and head outputs held; responses still accepted.
- Redirect, which has priority over stall and pop:
  - FIFO flushed; fetch_pc and the response-PC counter <= {stc_pc_i[..:2],2'b00}; ghsr <= stc_ghsr_i.
  - discard <= outstanding - imem_rvld_i. A response in the redirect cycle is itself dropped.
  - Requests resume the cycle after discard reaches 0.
- Redirect back-to-back: each redirect recomputes discard from the current outstanding count.
- Mid-operation reset: immediate asynchronous clear to reset values. The memory side must also be reset.

Decomposition:
- Shared package holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH alongside the existing decode opcodes;
  - width parameters INST_WIDTH, PFU_PC_WIDTH, GHSR_WIDTH.
- One sub-module: pfu_fifo, a synchronous FIFO with flush, count output, and parameterised width and depth.

Test Plan:
- Reset release with RESET_PC=0, memory gnt=1 and 1-cycle latency, dcu_rdy=1 -> imem_addr_o 0,4,8 on successive cycles; pfu_pc_o 0,4,8 with pfu_vld_o continuous after the first response.
- dcu_rdy=0 for 6 cycles -> exactly 2 requests issued, imem_req_o then 0. Releasing dcu_rdy drains PC 0 then 4, and requests resume.
- Redirect to 0x104 with 2 outstanding -> both stale responses dropped, no pfu_vld_o for them. Next request address 0x104; first output pfu_pc_o=0x104.
- Fetched word 0x0000_006F (JAL) with ghsr=0xFF -> pfu_j_b_en_o=1, pfu_ghsr_o=0xFF; next instruction carries 0xFE.
- stc_stall_i held 3 cycles with 1 FIFO entry -> pfu_vld_o=0, head unchanged, no request. Stall and redirect asserted together -> redirect taken.
- rst_i dropped mid-stream with 2 outstanding -> outputs 0 immediately; after release, fetch restarts at RESET_PC.
